// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU datapath blocks.
package alu4_pkg;

    // Default operand width used across the ALU.
    localparam int ALU_WIDTH = 4;

    // Sequencing states of the bit-serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_serial_state_t;

endpackage

// File: rtl/add1.sv
// One-bit full adder cell, purely combinational.
module add1 (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic out,
    output logic carry_out
);

    // Sum and carry of a single bit position.
    always_comb begin
        out       = a ^ b ^ carry_in;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
    end

endmodule

// File: rtl/add_serial.sv
// Bit-serial adder: operands are shifted LSB-first through one full-adder
// cell, with the carry loop closed through a flop. Results are returned
// over a valid/ready handshake together with carry-out and signed overflow.
module add_serial
    import alu4_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    add_serial_state_t state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  sum_sr;
    logic              carry_q;
    logic [CW-1:0]     count;
    logic              bit_sum;
    logic              bit_carry;

    add1 u_add1 (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .carry_in  (carry_q),
        .out       (bit_sum),
        .carry_out (bit_carry)
    );

    // Accept only in IDLE, and never while reset is being held.
    assign in_ready = (state == IDLE) & rst_n;
    assign sum      = sum_sr;

    // Sequencer: load operands, shift one bit per clock, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry_q   <= 1'b0;
            count     <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= carry_in;
                        count   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    sum_sr  <= {bit_sum, sum_sr[WIDTH-1:1]};
                    carry_q <= bit_carry;
                    count   <= count + CW'(1);
                    if (count == LAST) begin
                        overflow  <= carry_q ^ bit_carry;
                        carry_out <= bit_carry;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
